hex_line_parser: RTL and testbench
==================================

HEX_LINE_PARSER -- requirements
Module: hex_line_parser

Interface
REQ-001 Parameter WIDTH, default 16, value width in bits; SHALL be a multiple of 4.
REQ-002 Parameter LBL_MAX, default 4, maximum label length in characters.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: in_data carries a character.
REQ-006 Port in_data, input, 8: ASCII character.
REQ-007 Port in_ready, output, 1: parser accepts a character; a byte transfers when in_valid && in_ready.
REQ-008 Port out_valid, output, 1: parsed record available.
REQ-009 Port out_ready, input, 1: consumer accepts the record.
REQ-010 Port out_label, output, 8*LBL_MAX: label characters, right-justified, first char most significant, upper bytes zero.
REQ-011 Port out_value, output, WIDTH: parsed hex value.
REQ-012 Port out_err, output, 1: one-cycle pulse on a malformed line.

Function
REQ-013 Line syntax: label "=" hexdigits "\n". The parser SHALL ignore "\r" and "_" in every state.
REQ-014 States: S_LABEL, S_VALUE, S_HOLD, S_SKIP. Reset state is S_LABEL.
REQ-015 in_ready SHALL be 1 in every state except S_HOLD.
REQ-016 S_LABEL, character other than "=" or "\n":
- Shift the character into the label (shift left 8).
- Increment the label count.
- If the label count already equals LBL_MAX: error.
REQ-017 S_LABEL, "=": go to S_VALUE if the label count > 0; otherwise error.
REQ-018 S_LABEL, "\n": ignored if the label count is 0 (blank line); otherwise error.
REQ-019 S_VALUE, hex digit:
- value = (value << 4) | nibble.
- Increment the digit count.
- A digit arriving when the count already equals WIDTH/4: error.
REQ-020 S_VALUE, "\n": go to S_HOLD if the digit count > 0; otherwise error. Any other non-hex character: error.
REQ-021 out_valid SHALL assert the cycle after "\n" is accepted. out_valid, out_label and out_value SHALL stay stable until out_valid && out_ready.
REQ-022 On the out_valid && out_ready handshake: clear the label, value and counts, deassert out_valid the next cycle, and return to S_LABEL.
REQ-023 Error handling:
- Pulse out_err high for exactly the cycle after the offending byte.
- Discard the partial record.
- If the offending byte is "\n", go to S_LABEL; otherwise go to S_SKIP.
REQ-024 S_SKIP SHALL discard all bytes through the next "\n", then enter S_LABEL. No out_valid SHALL be produced for the discarded line.
REQ-025 Throughput SHALL be one byte per cycle outside S_HOLD. Back-to-back lines SHALL lose no bytes.

Reset
REQ-026 During rst, all outputs SHALL be driven as follows:
- out_valid = 0, out_err = 0.
- out_label = 0, out_value = 0.
- in_ready = 1.
REQ-027 rst asserted mid-line or in S_HOLD SHALL discard all partial or pending data. Parsing SHALL resume in S_LABEL the cycle after rst deasserts.

Configuration
REQ-028 Macro HEX_PARSE_UPPERCASE_EN:
- Defined: "A"-"F" SHALL be accepted as hex digits equal to "a"-"f".
- Undefined: "A"-"F" in S_VALUE SHALL be an error; they remain legal label characters.

Structure
REQ-029 Package hex_parse_pkg SHALL hold:
- The state enum.
- ASCII constants for "=", "\n", "\r" and "_".
REQ-030 Sub-module hex_char_decode SHALL be combinational: input 8-bit char; outputs is_hex and a 4-bit nibble. It honours HEX_PARSE_UPPERCASE_EN.

Verification
REQ-031 Basic record: "abcd=abcd\n" with out_ready=1 -> out_valid for one cycle, out_label=32'h61626364, out_value=16'habcd, out_err=0.
REQ-032 Back-to-back records: "ab0d=ab0d\n" followed immediately by "x=7\n", out_ready=1 -> two records, in order: (32'h61623064, 16'hab0d) then (32'h00000078, 16'h0007).
REQ-033 Backpressure: out_ready=0 for 5 cycles after "q=12\n" -> in_ready=0 and outputs stable throughout; the record transfers when out_ready rises, and in_ready=1 the next cycle.
REQ-034 Errors: "x=12345\n" -> out_err pulse on the 5th digit, no out_valid. "=1\n" -> out_err on "=". A following "y=1\n" -> parses correctly.
REQ-035 Uppercase: "v=AB\n" -> 16'h00ab with HEX_PARSE_UPPERCASE_EN defined; out_err and no record without it.
REQ-036 Reset: rst pulsed after "ab=1" -> no output; a subsequent "c=2\n" -> out_label=32'h63, out_value=16'h2.

Source files
------------

// File: rtl/hex_parse_pkg.sv
// rtl/hex_parse_pkg.sv - Shared state encoding and ASCII constants for the hex line parser.
package hex_parse_pkg;

  typedef enum logic [1:0] {
    S_LABEL,
    S_VALUE,
    S_HOLD,
    S_SKIP
  } state_t;

  localparam logic [7:0] CH_EQ = 8'h3d;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_US = 8'h5f;

endpackage

// File: rtl/hex_char_decode.sv
// rtl/hex_char_decode.sv - Combinational ASCII hex digit decoder; HEX_PARSE_UPPERCASE_EN adds A-F.
module hex_char_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
`ifdef HEX_PARSE_UPPERCASE_EN
    else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
`else
`endif
  end

endmodule

// File: rtl/hex_line_parser.sv
// rtl/hex_line_parser.sv - Parses "label=hex\n" lines into records; HEX_PARSE_UPPERCASE_EN selects A-F digits.
module hex_line_parser
  import hex_parse_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LBL_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LBL_MAX-1:0] out_label,
  output logic [WIDTH-1:0]     out_value,
  output logic                 out_err
);

  localparam int LW     = 8 * LBL_MAX;
  localparam int DIGITS = WIDTH / 4;
  localparam int LCW    = $clog2(LBL_MAX + 1);
  localparam int DCW    = $clog2(DIGITS + 1);

  state_t           state_q;
  logic [LW-1:0]    label_q;
  logic [WIDTH-1:0] value_q;
  logic [LCW-1:0]   lcnt_q;
  logic [DCW-1:0]   dcnt_q;
  logic             out_valid_q;
  logic             out_err_q;

  logic       is_hex;
  logic [3:0] nibble;
  logic       take;
  logic       err_hit;

  hex_char_decode u_dec (
    .ch     (in_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  // "\r" and "_" are transferred but never reach the state machine.
  assign take = in_valid && (state_q != S_HOLD) && !(in_data == CH_CR || in_data == CH_US);

  always_comb begin
    err_hit = 1'b0;
    if (take) begin
      case (state_q)
        S_LABEL: begin
          if (in_data == CH_LF)      err_hit = (lcnt_q != '0);
          else if (in_data == CH_EQ) err_hit = (lcnt_q == '0);
          else                       err_hit = (lcnt_q == LCW'(LBL_MAX));
        end
        S_VALUE: begin
          if (in_data == CH_LF) err_hit = (dcnt_q == '0);
          else if (!is_hex)     err_hit = 1'b1;
          else                  err_hit = (dcnt_q == DCW'(DIGITS));
        end
        default: err_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LABEL;
      label_q     <= '0;
      value_q     <= '0;
      lcnt_q      <= '0;
      dcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_err_q <= 1'b0;
      if (err_hit) begin
        out_err_q <= 1'b1;
        label_q   <= '0;
        value_q   <= '0;
        lcnt_q    <= '0;
        dcnt_q    <= '0;
        state_q   <= (in_data == CH_LF) ? S_LABEL : S_SKIP;
      end else if (state_q == S_HOLD) begin
        if (out_ready) begin
          out_valid_q <= 1'b0;
          label_q     <= '0;
          value_q     <= '0;
          lcnt_q      <= '0;
          dcnt_q      <= '0;
          state_q     <= S_LABEL;
        end
      end else if (take) begin
        case (state_q)
          S_LABEL: begin
            if (in_data == CH_EQ) begin
              state_q <= S_VALUE;
            end else if (in_data != CH_LF) begin
              label_q <= (label_q << 8) | LW'(in_data);
              lcnt_q  <= lcnt_q + LCW'(1);
            end
          end
          S_VALUE: begin
            if (in_data == CH_LF) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              value_q <= (value_q << 4) | WIDTH'(nibble);
              dcnt_q  <= dcnt_q + DCW'(1);
            end
          end
          S_SKIP: begin
            if (in_data == CH_LF) state_q <= S_LABEL;
          end
          default: state_q <= S_LABEL;
        endcase
      end
    end
  end

  // Outputs are forced to their idle values for the whole time rst is high.
  assign in_ready  = rst || (state_q != S_HOLD);
  assign out_valid = out_valid_q && !rst;
  assign out_err   = out_err_q && !rst;
  assign out_label = rst ? '0 : label_q;
  assign out_value = rst ? '0 : value_q;

endmodule

// File: tb/tb_hex_line_parser.sv
// tb/tb_hex_line_parser.sv - Scoreboard bench for hex_line_parser.
module tb_hex_line_parser;

  localparam int WIDTH   = 16;
  localparam int LBL_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [7:0]           in_data = 8'h00;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [8*LBL_MAX-1:0] out_label;
  logic [WIDTH-1:0]     out_value;
  logic                 out_err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int valid_cycles = 0;
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];

  hex_line_parser #(.WIDTH(WIDTH), .LBL_MAX(LBL_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_label (out_label),
    .out_value (out_value),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_label, out_value});
    if (out_err) err_seen++;
    if (out_valid) valid_cycles++;
  end

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = s[i];
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL send_timeout char=%0d in_ready=%b required=1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    int t = 0;
    while (got_q.size() < n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    checks++; if (out_label !== 32'h0) begin errors++; $display("FAIL reset_out_label got=%h exp=0", out_label); end
    checks++; if (out_value !== 16'h0) begin errors++; $display("FAIL reset_out_value got=%h exp=0", out_value); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int v0 = valid_cycles;
    int e0 = err_seen;
    logic [47:0] e, g;
    exp_q.push_back({32'h61626364, 16'habcd});
    send_str("abcd=abcd\n");
    settle(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL basic_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL basic_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles - v0); end
    checks++; if (err_seen != e0) begin errors++; $display("FAIL basic_err got=%0d exp=0", err_seen - e0); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] e, g;
    exp_q.push_back({32'h61623064, 16'hab0d});
    exp_q.push_back({32'h00000078, 16'h0007});
    send_str("ab0d=ab0d\nx=7\n");
    settle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL b2b_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL b2b_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b_extra got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [47:0] e, g;
    out_ready = 1'b0;
    exp_q.push_back({32'h00000071, 16'h0012});
    send_str("q=12\n");
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_label !== 32'h71 || out_value !== 16'h12) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b lbl=%h val=%h exp rdy=0 vld=1 lbl=71 val=0012",
                 c, in_ready, out_valid, out_label, out_value);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    settle(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL bp_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL bp_record got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_errors();
    int e0 = err_seen;
    logic [47:0] e, g;
    send_str("x=12345");
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_5th_digit got=%b exp=1", out_err); end
    send_str("\n");
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL err_skip_lf got=%b exp=0", out_err); end
    send_str("=");
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_empty_label got=%b exp=1", out_err); end
    send_str("1\n");
    exp_q.push_back({32'h00000079, 16'h0001});
    send_str("y=1\n");
    settle(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL err_recover_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL err_recover_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL err_extra_records got=%0d exp=0", got_q.size()); end
    checks++; if (err_seen - e0 != 2) begin errors++; $display("FAIL err_pulse_count got=%0d exp=2", err_seen - e0); end
  endtask

  task automatic test_boundaries();
    int e0 = err_seen;
    logic [47:0] e, g;
    send_str("\n");
    send_str("abcde=1\n");
    send_str("k=\n");
    exp_q.push_back({32'h7778797a, 16'hffff});
    exp_q.push_back({32'h00000061, 16'h0012});
    exp_q.push_back({32'h0000006d, 16'h0005});
    send_str("wxyz=ffff\na_\r=1_2\r\nm=5\n");
    settle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL bnd_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL bnd_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bnd_extra got=%0d exp=0", got_q.size()); end
    checks++; if (err_seen - e0 != 2) begin errors++; $display("FAIL bnd_err_count got=%0d exp=2", err_seen - e0); end
  endtask

  task automatic test_uppercase();
    int e0 = err_seen;
    logic [47:0] e, g;
    int exp_err;
`ifdef HEX_PARSE_UPPERCASE_EN
    exp_q.push_back({32'h00000076, 16'h00ab});
    exp_err = 0;
`else
    exp_err = 1;
`endif
    send_str("v=AB\n");
    settle(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL upper_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL upper_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL upper_extra got=%0d exp=0", got_q.size()); end
    checks++; if (err_seen - e0 != exp_err) begin errors++; $display("FAIL upper_err got=%0d exp=%0d", err_seen - e0, exp_err); end
  endtask

  task automatic test_reset_mid();
    logic [47:0] e, g;
    send_str("ab=1");
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_label !== 32'h0 || out_value !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs got vld=%b lbl=%h val=%h rdy=%b exp 0/0/0/1", out_valid, out_label, out_value, in_ready);
    end
    rst = 1'b0;
    exp_q.push_back({32'h00000063, 16'h0002});
    send_str("c=2\n");
    settle(1);
    out_ready = 1'b0;
    send_str("d=3\n");
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_pending got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_during got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    settle(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL rst_missing got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL rst_record got=%h exp=%h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_extra got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_boundaries();
    test_uppercase();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
